discrete_audio_i2s_out: RTL and testbench
=========================================

Name: discrete_audio_i2s_out

Overview:
Audio sink at the far end of the discrete-sound sample interface. It generates the `audio_clk_en` sample strobe consumed by every discrete circuit (walk, jump, etc.). One clk after each strobe it captures the circuit's registered 16-bit signed `out` sample. It serializes that sample, mono duplicated to left and right, as Philips I2S master output toward the board DAC/HDMI path.

Parameters:
- CLOCK_RATE, 24576000, clk frequency in Hz; must be ≥ 128*SAMPLE_RATE (elaboration-time $error otherwise).
- SAMPLE_RATE, 48000, audio frame rate in Hz; one `audio_clk_en` pulse per frame.

Ports:
- clk  input  1  system clock.
- I_RSTn  input  1  reset; asynchronous, active-low.
- in_sample  input  16  signed sample from the discrete circuit; sampled one clk after `audio_clk_en`.
- audio_clk_en  output  1  one-clk sample strobe, once per frame.
- i2s_sclk  output  1  bit clock, 64*SAMPLE_RATE nominal.
- i2s_lrclk  output  1  word select; 0 = left, 1 = right.
- i2s_sdata  output  1  serial data, MSB first.
- frame_start  output  1  one-clk pulse on the falling-edge event entering slot 0.

Behaviour:
- Reset values (all outputs and state):
  - Outputs: `audio_clk_en`=0, `i2s_sclk`=0, `i2s_lrclk`=1, `i2s_sdata`=0, `frame_start`=0.
  - Internal: accumulator=0, slot counter=63, held sample=0, tx word=0, capture-pending=0.
- Bit clock generation:
  - 32-bit phase accumulator; each clk adds INC = 128*SAMPLE_RATE.
  - When acc+INC ≥ CLOCK_RATE: store acc+INC−CLOCK_RATE and toggle `i2s_sclk` that cycle. Otherwise store acc+INC.
  - At defaults, `i2s_sclk` toggles every 4 clks (period 8 clks); frame = 512 clks.
- Falling-edge event: the clk cycle in which `i2s_sclk` toggles 1→0. All slot-related updates happen only on this event, registered in the same cycle as the toggle.
  - The slot counter increments modulo 64 (63→0 wraps).
  - `i2s_lrclk` = new_slot[5].
- Data per slot, with p = new_slot[4:0]:
  - p=0 → `i2s_sdata`=0 (one-bit I2S delay).
  - p=1..16 → `i2s_sdata` = tx_word[16−p].
  - p=17..31 → `i2s_sdata`=0.
  - The same tx_word is used for both the left and right halves.
- Frame start (falling-edge event entering slot 0):
  - tx_word ← held sample.
  - `frame_start`=1 for that clk.
  - Slot 0 therefore carries 0, slot 1 carries tx_word[15].
- Sample strobe and capture:
  - On the falling-edge event entering slot 48, `audio_clk_en`=1 for exactly that clk. It is 0 on all other clks.
  - The next clk sets capture-pending: held sample ← `in_sample`, and pending clears the same cycle.
  - Capture is thus one clk after the strobe, matching sources that register `out` on `audio_clk_en`.
- Latency:
  - A sample captured in frame N is transmitted starting at slot 1 of frame N+1, i.e. after the next frame_start.
  - First post-reset frame transmits held sample 0.
- Simultaneous events: a capture and a frame-start load cannot coincide (16 slots apart); no arbitration is required.
- Reset mid-frame: asserting I_RSTn low forces all registers to reset values immediately (asynchronous). After release, the bit clock restarts from phase 0, and the first falling edge enters slot 0.
- Arithmetic:
  - No saturation in the pass-through path.
  - Accumulator compare is unsigned 32-bit; INC and CLOCK_RATE are computed as 32-bit localparams.

Optional Feature:
- Macro: `DISCRETE_AUDIO_SOFT_START_EN`.
- With the macro defined:
  - A 9-bit gain counter resets to 0 and increments on each frame_start until it reaches 256, then holds.
  - tx_word ← (held_sample * gain) >>> 8, as a 25-bit signed product truncated to 16 bits. This removes the power-on pop.
  - Reset mid-operation restarts the ramp from 0.
- Without the macro: tx_word ← held sample directly; no gain logic is instantiated.

Test Plan:
1. Defaults, reset released → `i2s_sclk` period 8 clks; `audio_clk_en` pulses every 512 clks ±0; `frame_start` every 512 clks; `i2s_lrclk` toggles every 256 clks.
2. Hold `in_sample`=16'h8001 → after the second frame_start, left and right slots 1..16 show 1000_0000_0000_0001; slots 0 and 17..31 show 0.
3. Change `in_sample` from 16'h1234 to 16'h5678 on the clk of `audio_clk_en`; the source registers the new value at that edge → 16'h5678 is captured and transmitted in the next frame.
4. CLOCK_RATE=50000000, SAMPLE_RATE=48000 → over 100 frames the average `audio_clk_en` interval is 1041.67 clks; every individual interval is 1041 or 1042.
5. Assert I_RSTn low at slot 20 → outputs immediately reach reset values; after release, the first frame transmits 0.
6. With `DISCRETE_AUDIO_SOFT_START_EN` and `in_sample`=16'h4000 → frame k (k<256) transmits (0x4000*k)>>>8 = 64*k; from frame 256 on it transmits 16'h4000.

Source files
------------

// File: rtl/discrete_audio_i2s_out.sv
// discrete_audio_i2s_out: audio sink for the discrete sound circuits.
// Generates the per-frame sample strobe audio_clk_en, captures in_sample
// one clk after that strobe, and serializes the sample as mono Philips I2S
// (same word on left and right), MSB first, with a one-bit delay.
// Ports: clk, I_RSTn (async, active-low), in_sample[15:0] (signed) in;
//        audio_clk_en, i2s_sclk, i2s_lrclk, i2s_sdata, frame_start out.
// Optional: define DISCRETE_AUDIO_SOFT_START_EN to ramp the gain from 0 to 1
//           over the first 256 frames after reset (removes power-on pop).
module discrete_audio_i2s_out #(
   parameter int unsigned CLOCK_RATE  = 24576000,
   parameter int unsigned SAMPLE_RATE = 48000
) (
   input  logic               clk,
   input  logic               I_RSTn,
   input  logic signed [15:0] in_sample,
   output logic               audio_clk_en,
   output logic               i2s_sclk,
   output logic               i2s_lrclk,
   output logic               i2s_sdata,
   output logic               frame_start
);

   localparam logic [31:0] INC = 32'(128 * SAMPLE_RATE);
   localparam logic [31:0] CR  = 32'(CLOCK_RATE);

   generate
      if (CLOCK_RATE < 128 * SAMPLE_RATE) begin : g_rate_chk
         $error("CLOCK_RATE must be at least 128*SAMPLE_RATE");
      end
   endgenerate

   logic [31:0]        acc;
   logic [5:0]         slot;
   logic signed [15:0] held;
   logic [15:0]        tx_word;
   logic               pending;

   logic [32:0]        sum;
   logic               wrap;
   logic [31:0]        acc_nxt;
   logic               fall;
   logic [5:0]         slot_nxt;
   logic [4:0]         pos;
   logic [3:0]         bit_idx;
   logic               sd_nxt;
   logic [15:0]        tx_load;

`ifdef DISCRETE_AUDIO_SOFT_START_EN
   logic [8:0]         gain;
   logic signed [25:0] prod;

   always_comb begin
      prod    = held * $signed({1'b0, gain});
      tx_load = prod[23:8];
   end
`else
   always_comb begin
      tx_load = held;
   end
`endif

   always_comb begin
      sum      = {1'b0, acc} + {1'b0, INC};
      wrap     = (sum >= {1'b0, CR});
      acc_nxt  = wrap ? 32'(sum - {1'b0, CR}) : sum[31:0];
      // A wrap while the bit clock is high is the 1->0 edge.
      fall     = wrap & i2s_sclk;
      slot_nxt = slot + 6'd1;
      pos      = slot_nxt[4:0];
      bit_idx  = 4'(5'd16 - pos);
      sd_nxt   = 1'b0;
      if (pos != 5'd0 && pos <= 5'd16) begin
         sd_nxt = tx_word[bit_idx];
      end
   end

   always_ff @(posedge clk or negedge I_RSTn) begin
      if (!I_RSTn) begin
         acc          <= '0;
         slot         <= 6'd63;
         held         <= '0;
         tx_word      <= '0;
         pending      <= 1'b0;
         audio_clk_en <= 1'b0;
         i2s_sclk     <= 1'b0;
         i2s_lrclk    <= 1'b1;
         i2s_sdata    <= 1'b0;
         frame_start  <= 1'b0;
      end else begin
         acc          <= acc_nxt;
         if (wrap) begin
            i2s_sclk <= ~i2s_sclk;
         end
         frame_start  <= fall && (slot_nxt == 6'd0);
         audio_clk_en <= fall && (slot_nxt == 6'd48);
         // Source registers its sample on the strobe; take it a clk later.
         pending      <= audio_clk_en;
         if (pending) begin
            held <= in_sample;
         end
         if (fall) begin
            slot      <= slot_nxt;
            i2s_lrclk <= slot_nxt[5];
            i2s_sdata <= sd_nxt;
            if (slot_nxt == 6'd0) begin
               tx_word <= tx_load;
            end
         end
      end
   end

`ifdef DISCRETE_AUDIO_SOFT_START_EN
   always_ff @(posedge clk or negedge I_RSTn) begin
      if (!I_RSTn) begin
         gain <= '0;
      end else if (fall && slot_nxt == 6'd0 && gain != 9'd256) begin
         gain <= gain + 9'd1;
      end
   end
`endif

endmodule

// File: tb/tb_discrete_audio_i2s_out.sv
// Bench for discrete_audio_i2s_out: table-driven samples checked through a
// scoreboard of I2S frames, plus timing, reset and fractional-rate checks.
module tb_discrete_audio_i2s_out;

   typedef struct {
      logic [15:0] din;
      logic [15:0] dout;
   } vec_t;

   logic        clk = 1'b0;
   logic        I_RSTn = 1'b0;
   logic [15:0] in_sample = 16'h0;
   logic        audio_clk_en, i2s_sclk, i2s_lrclk, i2s_sdata, frame_start;
   logic        f_aen, f_sclk, f_lr, f_sd, f_fs;

   int          total = 0;
   int          bad = 0;
   logic [15:0] sb[$];

   always #5 clk = ~clk;

   discrete_audio_i2s_out dut (
      .clk(clk), .I_RSTn(I_RSTn), .in_sample(in_sample),
      .audio_clk_en(audio_clk_en), .i2s_sclk(i2s_sclk),
      .i2s_lrclk(i2s_lrclk), .i2s_sdata(i2s_sdata),
      .frame_start(frame_start)
   );

   discrete_audio_i2s_out #(.CLOCK_RATE(50000000), .SAMPLE_RATE(48000))
   dut_fast (
      .clk(clk), .I_RSTn(I_RSTn), .in_sample(in_sample),
      .audio_clk_en(f_aen), .i2s_sclk(f_sclk),
      .i2s_lrclk(f_lr), .i2s_sdata(f_sd),
      .frame_start(f_fs)
   );

   task automatic check(input string nm, input logic [63:0] act,
                        input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Frame monitor: sample sdata/lrclk on sclk rising edges after frame_start.
   int          bitcnt = 0;
   logic        collecting = 1'b0;
   logic        sclk_q = 1'b0;
   logic [63:0] got_sd, got_lr, exp_sd;
   logic [15:0] w;

   always @(negedge clk) begin
      if (!I_RSTn) begin
         collecting = 1'b0;
      end else begin
         if (frame_start) begin
            bitcnt     = 0;
            collecting = 1'b1;
         end
         if (collecting && i2s_sclk && !sclk_q) begin
            got_sd[63-bitcnt] = i2s_sdata;
            got_lr[63-bitcnt] = i2s_lrclk;
            bitcnt++;
            if (bitcnt == 64) begin
               collecting = 1'b0;
               if (sb.size() == 0) begin
                  check("scoreboard_empty", 64'd0, 64'd1);
               end else begin
                  w      = sb.pop_front();
                  exp_sd = {1'b0, w, 15'h0, 1'b0, w, 15'h0};
                  check("frame_sdata", got_sd, exp_sd);
                  check("frame_lrclk", got_lr, {32'h0, 32'hFFFF_FFFF});
               end
            end
         end
      end
      sclk_q = i2s_sclk;
   end

   // Timing monitor for the default-rate instance.
   int   cyc = 0;
   int   t_sclk = -1, t_aen = -1, t_fs = -1, t_lr = -1;
   logic lr_q = 1'b1, sc_q = 1'b0, aen_q = 1'b0;

   always @(negedge clk) begin
      cyc++;
      if (!I_RSTn) begin
         t_sclk = -1; t_aen = -1; t_fs = -1; t_lr = -1;
      end else begin
         if (i2s_sclk && !sc_q) begin
            if (t_sclk >= 0) check("sclk_period", 64'(cyc - t_sclk), 64'd8);
            t_sclk = cyc;
         end
         if (i2s_lrclk != lr_q) begin
            if (t_lr >= 0) check("lrclk_half", 64'(cyc - t_lr), 64'd256);
            t_lr = cyc;
         end
         if (frame_start) begin
            if (t_fs >= 0) check("fs_period", 64'(cyc - t_fs), 64'd512);
            t_fs = cyc;
         end
         if (audio_clk_en && !aen_q) begin
            if (t_aen >= 0) check("aen_period", 64'(cyc - t_aen), 64'd512);
            if (t_fs >= 0) check("aen_after_fs", 64'(cyc - t_fs), 64'd384);
            t_aen = cyc;
         end
         if (aen_q && audio_clk_en) check("aen_width", 64'd2, 64'd1);
      end
      sc_q  = i2s_sclk;
      lr_q  = i2s_lrclk;
      aen_q = audio_clk_en;
   end

   // Fractional-rate instance: 50 MHz clk, 48 kHz frames.
   int   f_last = -1, f_n = 0, f_sum = 0, iv;
   logic f_done = 1'b0;

   always @(negedge clk) begin
      if (!I_RSTn) begin
         f_last = -1; f_n = 0; f_sum = 0;
      end else if (f_aen && !f_done) begin
         if (f_last >= 0) begin
            iv = cyc - f_last;
            check("fast_interval", 64'(iv == 1041 || iv == 1042), 64'd1);
            f_sum += iv;
            f_n++;
            if (f_n == 40) begin
               check("fast_sum40", 64'(f_sum == 41666 || f_sum == 41667), 64'd1);
               f_done = 1'b1;
            end
         end
         f_last = cyc;
      end
   end

   // Drive the next sample the way a source registering on the strobe would.
   task automatic feed(input logic [15:0] v, input logic [15:0] e);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!audio_clk_en && n < 2000);
      if (!audio_clk_en) begin
         check("strobe_timeout", 64'd0, 64'd1);
      end else begin
         @(posedge clk);
         #1 in_sample = v;
         sb.push_back(e);
      end
   endtask

   vec_t vt[10];
   int   n;

   initial begin
      vt[0] = '{16'h8001, 16'h8001};
      vt[1] = '{16'h8001, 16'h8001};
      vt[2] = '{16'h1234, 16'h1234};
      vt[3] = '{16'h5678, 16'h5678};
      vt[4] = '{16'h0000, 16'h0000};
      vt[5] = '{16'hFFFF, 16'hFFFF};
      vt[6] = '{16'h7FFF, 16'h7FFF};
      vt[7] = '{16'h8000, 16'h8000};
      vt[8] = '{16'hA5A5, 16'hA5A5};
      vt[9] = '{16'h0001, 16'h0001};

      in_sample = 16'h8001;
      sb.push_back(16'h0000);
      repeat (3) @(negedge clk);
      check("rst_aen", 64'(audio_clk_en), 64'd0);
      check("rst_sclk", 64'(i2s_sclk), 64'd0);
      check("rst_lrclk", 64'(i2s_lrclk), 64'd1);
      check("rst_sdata", 64'(i2s_sdata), 64'd0);
      check("rst_fs", 64'(frame_start), 64'd0);
      @(posedge clk);
      #2 I_RSTn = 1'b1;

      for (int i = 0; i < 10; i++) begin
         feed(vt[i].din, vt[i].dout);
      end

      // Mid-frame reset at slot 20.
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!frame_start && n < 2000);
      check("fs_seen", 64'(frame_start), 64'd1);
      repeat (20 * 8 + 4) @(negedge clk);
      @(posedge clk);
      #2 I_RSTn = 1'b0;
      sb.delete();
      sb.push_back(16'h0000);
      #1;
      check("midrst_aen", 64'(audio_clk_en), 64'd0);
      check("midrst_sclk", 64'(i2s_sclk), 64'd0);
      check("midrst_lrclk", 64'(i2s_lrclk), 64'd1);
      check("midrst_sdata", 64'(i2s_sdata), 64'd0);
      check("midrst_fs", 64'(frame_start), 64'd0);
      repeat (3) @(negedge clk);
      @(posedge clk);
      #2 I_RSTn = 1'b1;

      for (int i = 0; i < 120 && !f_done; i++) begin
         logic [15:0] v;
         v = 16'($urandom);
         feed(v, v);
      end
      check("fast_done", 64'(f_done), 64'd1);

      n = 0;
      while (sb.size() != 0 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check("drain", 64'(sb.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
